// File: rtl/fp16_pkg.sv
// Shared fp16 types and constants for the argmax datapath.
package fp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } argmax_state_e;

  function automatic logic fp16_is_nan(input fp16_t v);
    return (v.exp == FP16_EXP_MAX) && (v.man != '0);
  endfunction

endpackage

// File: rtl/new_fp16_cmp.sv
// fp16 magnitude comparator: result_o = operands_i[1] >= operands_i[0].
// Sign decides first (+0 beats -0); equal signs compare {exp,man}, reversed when negative.
module new_fp16_cmp
  import fp16_pkg::*;
(
  input  fp16_t [1:0] operands_i,
  output logic        result_o
);

  fp16_t a;
  fp16_t b;

  // Ordered comparison of a against b
  always_comb begin
    a = operands_i[1];
    b = operands_i[0];
    if (a.sign != b.sign) begin
      result_o = ~a.sign;
    end else if (a.sign) begin
      result_o = ({a.exp, a.man} <= {b.exp, b.man});
    end else begin
      result_o = ({a.exp, a.man} >= {b.exp, b.man});
    end
  end

endmodule

// File: rtl/fp16_argmax_seq.sv
// Streaming max/argmax over fp16 vectors with a held result port.
// Optional NaN filtering and out_nan_o port: define FP16_ARGMAX_NAN_EN.
module fp16_argmax_seq
  import fp16_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 64,
  localparam int unsigned IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_max_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [IDX_W:0]   out_cnt_o,
  output logic             out_ovf_o,
`ifdef FP16_ARGMAX_NAN_EN
  output logic             out_nan_o,
`endif
  output logic             busy_o
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

  argmax_state_e    state_q, state_d;
  fp16_t            max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [15:0]      out_max_q, out_max_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W:0]   out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;
`ifdef FP16_ARGMAX_NAN_EN
  logic             have_q, have_d;
  logic             nan_q, nan_d;
  logic             out_nan_q, out_nan_d;
  logic             data_nan;
`endif

  fp16_t          data;
  logic           cmp_ge;
  logic           replace;
  logic           accept;
  logic           go_done;
  logic           ovf;
  logic [IDX_W:0] cnt_inc;

  assign data = fp16_t'(in_data_i);

  new_fp16_cmp u_cmp (
    .operands_i ({data, max_q}),
    .result_o   (cmp_ge)
  );

  // Next-state, running max/index/count and result capture
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    go_done   = 1'b0;
    ovf       = 1'b0;
    accept    = in_valid_i && (state_q != DONE);
    cnt_inc   = cnt_q + CNT_ONE;
    // Strict greater: ties keep the earlier index
    replace   = cmp_ge && (data != max_q);
`ifdef FP16_ARGMAX_NAN_EN
    have_d    = have_q;
    nan_d     = nan_q;
    out_nan_d = out_nan_q;
    data_nan  = fp16_is_nan(data);
    // NaN never wins; the first non-NaN wins over an all-NaN prefix
    replace   = !data_nan && (!have_q || replace);
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          max_d = data;
          idx_d = '0;
          cnt_d = CNT_ONE;
`ifdef FP16_ARGMAX_NAN_EN
          have_d = !data_nan;
          nan_d  = data_nan;
          if (data_nan) max_d = fp16_t'(FP16_QNAN);
`endif
          if (in_last_i) go_done = 1'b1;
          else           state_d = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (replace) begin
            max_d = data;
            idx_d = cnt_q[IDX_W-1:0];
          end
          cnt_d = cnt_inc;
`ifdef FP16_ARGMAX_NAN_EN
          have_d = have_q || !data_nan;
          nan_d  = nan_q || data_nan;
`endif
          if (in_last_i || (cnt_inc == CNT_MAX)) begin
            go_done = 1'b1;
            ovf     = !in_last_i;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d   = IDLE;
          out_max_d = '0;
          out_idx_d = '0;
          out_cnt_d = '0;
          out_ovf_d = 1'b0;
`ifdef FP16_ARGMAX_NAN_EN
          out_nan_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_done) begin
      state_d   = DONE;
      out_max_d = max_d;
      out_idx_d = idx_d;
      out_cnt_d = cnt_d;
      out_ovf_d = ovf;
`ifdef FP16_ARGMAX_NAN_EN
      out_nan_d = nan_d;
`endif
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      out_max_q <= '0;
      out_idx_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
`ifdef FP16_ARGMAX_NAN_EN
      have_q    <= 1'b0;
      nan_q     <= 1'b0;
      out_nan_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      out_max_q <= out_max_d;
      out_idx_q <= out_idx_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
`ifdef FP16_ARGMAX_NAN_EN
      have_q    <= have_d;
      nan_q     <= nan_d;
      out_nan_q <= out_nan_d;
`endif
    end
  end

  assign in_ready_o  = (state_q != DONE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_max_o   = out_max_q;
  assign out_idx_o   = out_idx_q;
  assign out_cnt_o   = out_cnt_q;
  assign out_ovf_o   = out_ovf_q;
`ifdef FP16_ARGMAX_NAN_EN
  assign out_nan_o   = out_nan_q;
`endif

endmodule

// File: tb/tb_fp16_argmax_seq.sv
// Self-checking bench for fp16_argmax_seq (MAX_LEN=4); honours FP16_ARGMAX_NAN_EN.
module tb_fp16_argmax_seq;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN);

  logic             clk;
  logic             rst_ni;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_cnt;
  logic             out_ovf;
  logic             busy;
`ifdef FP16_ARGMAX_NAN_EN
  logic             out_nan;
  localparam bit    NAN_EN = 1'b1;
`else
  localparam bit    NAN_EN = 1'b0;
`endif

  fp16_argmax_seq #(.MAX_LEN(MAX_LEN)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_max_o   (out_max),
    .out_idx_o   (out_idx),
    .out_cnt_o   (out_cnt),
    .out_ovf_o   (out_ovf),
`ifdef FP16_ARGMAX_NAN_EN
    .out_nan_o   (out_nan),
`endif
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mx;
    int          idx;
    int          cnt;
    bit          ovf;
    bit          nan;
  } res_t;

  typedef struct {
    int          n;
    logic [15:0] d [6];
    res_t        exp_r;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] stim_d [$];
  bit          stim_l [$];
  res_t        exp_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input res_t e);
    chk({tag, "_max"}, 32'(out_max), 32'(e.mx));
    chk({tag, "_idx"}, 32'(out_idx), 32'(e.idx));
    chk({tag, "_cnt"}, 32'(out_cnt), 32'(e.cnt));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
`ifdef FP16_ARGMAX_NAN_EN
    chk({tag, "_nan"}, 32'(out_nan), 32'(e.nan));
`endif
  endtask

  // Total order of fp16 raw values: +0 > -0, larger magnitude is more negative
  function automatic int key(input logic [15:0] v);
    if (v[15]) return -int'(v[14:0]) - 1;
    return int'(v[14:0]);
  endfunction

  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  // Reference: chunk the beat stream into vectors and reduce each one
  task automatic build_expected();
    logic [15:0] cur [$];
    res_t r;
    int best;
    bit have;
    for (int i = 0; i < stim_d.size(); i++) begin
      cur.push_back(stim_d[i]);
      if (stim_l[i] || cur.size() == MAX_LEN) begin
        have = 1'b0;
        best = 0;
        r.idx = 0;
        r.nan = 1'b0;
        r.cnt = cur.size();
        r.ovf = !stim_l[i];
        for (int j = 0; j < cur.size(); j++) begin
          if (NAN_EN && is_nan(cur[j])) begin
            r.nan = 1'b1;
          end else if (!have || key(cur[j]) > best) begin
            have  = 1'b1;
            best  = key(cur[j]);
            r.idx = j;
          end
        end
        r.mx = have ? cur[r.idx] : 16'h7E00;
        exp_q.push_back(r);
        cur.delete();
      end
    end
  endtask

  // Drive stim_* with random valid/ready gaps; check each result as it is consumed
  task automatic run_stream(input string tag, input int vpct, input int rpct);
    int p = 0;
    int cyc = 0;
    res_t e;
    while ((p < stim_d.size() || exp_q.size() > 0) && cyc < 20000) begin
      in_valid  = (p < stim_d.size()) && ($urandom_range(99) < vpct);
      in_data   = in_valid ? stim_d[p] : 16'($urandom);
      in_last   = in_valid ? stim_l[p] : 1'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      if (out_valid && in_ready) begin
        chk({tag, "_ready_in_done"}, 32'(in_ready), 32'(0));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_result"}, 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check_result(tag, e);
        end
      end
      if (in_valid && in_ready) p++;
      tick();
      cyc++;
    end
    if (cyc >= 20000) chk({tag, "_timeout"}, 32'(cyc), 32'(0));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stim_d.delete();
    stim_l.delete();
    exp_q.delete();
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
  endtask

  vec_t tbl [7];
  res_t r0, r1;
  logic [15:0] pool [8];

  initial begin
    logic [15:0] held_max;
    rst_ni    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_out_max",   32'(out_max),   32'(0));
    chk("rst_out_cnt",   32'(out_cnt),   32'(0));
    rst_ni = 1'b1;
    tick();

    // Directed table
    tbl[0] = '{3, '{16'h3C00, 16'h4000, 16'h3800, 0, 0, 0}, '{16'h4000, 1, 3, 0, 0}};
    tbl[1] = '{4, '{16'hC000, 16'hBC00, 16'hBC00, 16'hC400, 0, 0}, '{16'hBC00, 1, 4, 0, 0}};
    tbl[2] = '{2, '{16'h8000, 16'h0000, 0, 0, 0, 0}, '{16'h0000, 1, 2, 0, 0}};
    tbl[3] = '{1, '{16'h3C00, 0, 0, 0, 0, 0}, '{16'h3C00, 0, 1, 0, 0}};
    tbl[4] = '{2, '{16'h0000, 16'h8000, 0, 0, 0, 0}, '{16'h0000, 0, 2, 0, 0}};
`ifdef FP16_ARGMAX_NAN_EN
    tbl[5] = '{3, '{16'h3C00, 16'h7E01, 16'h4000, 0, 0, 0}, '{16'h4000, 2, 3, 0, 1}};
    tbl[6] = '{1, '{16'h7C01, 0, 0, 0, 0, 0}, '{16'h7E00, 0, 1, 0, 1}};
`else
    tbl[5] = '{2, '{16'h3C00, 16'h7E01, 0, 0, 0, 0}, '{16'h7E01, 1, 2, 0, 0}};
    tbl[6] = '{2, '{16'hFC00, 16'hFC01, 0, 0, 0, 0}, '{16'hFC00, 0, 2, 0, 0}};
`endif
    for (int t = 0; t < 7; t++) begin
      for (int j = 0; j < tbl[t].n; j++) begin
        stim_d.push_back(tbl[t].d[j]);
        stim_l.push_back(j == tbl[t].n - 1);
      end
      exp_q.push_back(tbl[t].exp_r);
      run_stream($sformatf("tbl%0d", t), 100, 100);
    end

    // Latency: result valid exactly one cycle after the last beat is accepted
    out_ready = 1'b1;
    drive_beat(16'h3C00, 1'b0); tick();
    drive_beat(16'h4000, 1'b0); tick();
    drive_beat(16'h3800, 1'b1);
    chk("lat_before", 32'(out_valid), 32'(0));
    tick();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'(1));
    chk("lat_max",   32'(out_max),   32'(16'h4000));
    tick();
    chk("lat_release", 32'(out_valid), 32'(0));
    chk("lat_cleared", 32'(out_max),   32'(0));

    // Backpressure: result held and next vector stalled while out_ready_i=0
    out_ready = 1'b0;
    drive_beat(16'h3800, 1'b0); tick();
    drive_beat(16'h4400, 1'b1); tick();
    held_max = 16'h4400;
    drive_beat(16'h3C00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",    32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready),  32'(0));
      chk("bp_max",      32'(out_max),   32'(held_max));
      chk("bp_cnt",      32'(out_cnt),   32'(2));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_valid", 32'(out_valid), 32'(0));
    chk("bp_idle_busy",  32'(busy),      32'(0));
    chk("bp_idle_ready", 32'(in_ready),  32'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_next_max", 32'(out_max), 32'(16'h3C00));
    chk("bp_next_cnt", 32'(out_cnt), 32'(1));
    tick();

    // Overflow at MAX_LEN: 6 rising beats, last only on the 6th
    out_ready = 1'b1;
    stim_d = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4100, 16'h4200, 16'h4400};
    stim_l = '{0, 0, 0, 0, 0, 1};
    r0 = '{16'h4100, 3, 4, 1, 0};
    r1 = '{16'h4400, 1, 2, 0, 0};
    exp_q.push_back(r0);
    exp_q.push_back(r1);
    run_stream("ovf", 100, 100);

    // Mid-vector reset discards partial state
    drive_beat(16'h4800, 1'b0); tick();
    drive_beat(16'h4C00, 1'b0); tick();
    in_valid = 1'b0;
    rst_ni   = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("mrst_in_ready",  32'(in_ready),  32'(1));
    chk("mrst_out_valid", 32'(out_valid), 32'(0));
    chk("mrst_busy",      32'(busy),      32'(0));
    out_ready = 1'b0;
    drive_beat(16'h3C00, 1'b1); tick();
    in_valid = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'(1));
    chk("mrst_max",   32'(out_max),   32'(16'h3C00));
    chk("mrst_idx",   32'(out_idx),   32'(0));
    chk("mrst_cnt",   32'(out_cnt),   32'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized vectors against the reference model
    pool = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000, 16'h4000, 16'h7E01, 16'hFC00, 16'h7C00};
    for (int v = 0; v < 60; v++) begin
      int len;
      len = $urandom_range(6, 1);
      for (int j = 0; j < len; j++) begin
        stim_d.push_back(($urandom_range(1) == 0) ? pool[$urandom_range(7)] : 16'($urandom));
        stim_l.push_back(j == len - 1);
      end
    end
    build_expected();
    run_stream("rnd", 70, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
